mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit and its sequencer for the E stage of the pipelined MIPS core.
- Sits beside the ALU in E and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO, models fixed multi-cycle latency with a counter-driven state machine, and exposes Busy so the hazard unit can stall dependent MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, number of Busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  rs operand, forwarded value from E.
- B  input  32  rt operand, forwarded value from E.
- MduOp  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9..15 are treated as NONE.
- Start  input  1  E-stage instruction valid and not flushed; qualifies every state-changing op.
- Busy  output  1  registered; high while an issued multiply or divide is in progress.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- Out  output  32  combinational read data: HI when MduOp=MFHI, LO when MduOp=MFLO, 0 otherwise. Independent of Start.

Behaviour:
- Reset (reset=1 at an edge):
  - HI=0, LO=0, Busy=0, counter=0, state=IDLE.
  - Any in-flight operation is discarded; its result never reaches HI/LO.
- States: IDLE, RUN.
- IDLE, Start=1, MduOp in {MULT, MULTU, DIV, DIVU}:
  - At that edge, latch the computed result into internal pending HI/LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; Busy is high from the next cycle.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1: commit pending to HI/LO, clear Busy, return to IDLE.
  - Busy is therefore high for exactly N cycles. New HI/LO is visible in the first cycle Busy=0.
- Issue at edge k gives: Busy=1 during cycles k+1..k+N; HI/LO updated at edge k+N.
- Start is also a request: the hazard unit stalls a D-stage MDU instruction when Busy=1 or (Start=1 and MduOp is MULT/MULTU/DIV/DIVU).
- Arithmetic rules:
  - MULT: signed 32x32 -> 64-bit product; HI = product[63:32], LO = product[31:0].
  - MULTU: same split, unsigned operands.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder, carrying the sign of A.
  - DIVU: unsigned. LO = A/B, HI = A%B.
  - B=0 (DIV or DIVU): the operation still runs the full Busy period, but HI/LO are left unchanged at commit.
  - DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO with Start=1 in IDLE: HI or LO := A at that edge; no Busy.
- Any Start=1 op while in RUN (including MTHI/MTLO): ignored. HI/LO and the counter are unaffected. The hazard unit guarantees this does not occur in legal flow.
- MFHI/MFLO during RUN: Out returns the old, uncommitted HI/LO (stall is the hazard unit's responsibility).
- Start=0 or MduOp=NONE: no state change.
- reset asserted in the same cycle as Start: reset wins.

Test Plan:
- Reset, then idle: HI=LO=0, Busy=0, Out=0 for MduOp=MFHI.
- MULT A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MFLO/MFHI: HI updated on the next edge, Out=0x12345678 for MFHI. DIV by B=0 afterwards -> Busy for 10 cycles, HI stays 0x12345678.
- During RUN: issue MTLO 0xDEADBEEF and a second MULT -> both ignored; the original result commits on schedule.
- Assert reset at cycle 3 of a MULT -> Busy=0 and HI=LO=0 the next cycle; no commit two cycles later. Reset together with Start -> no operation begins.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage bundle between the pipeline and the multiply/divide unit.
//   A, B   : rs/rt operands forwarded into E
//   MduOp  : MDU operation code (0 NONE .. 8 MTLO, 9..15 treated as NONE)
//   Start  : E-stage instruction valid and not flushed
//   Busy   : multiply/divide in progress (registered)
//   HI, LO : architectural HI/LO registers
//   Out    : MFHI/MFLO read data (combinational)
// Modports: master = pipeline/testbench side, slave = mdu_ctrl side.
interface mdu_ctrl_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MduOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (output A, output B, output MduOp, output Start,
                  input Busy, input HI, input LO, input Out);
  modport slave  (input A, input B, input MduOp, input Start,
                  output Busy, output HI, output LO, output Out);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit and sequencer for the E stage.
// Owns HI/LO. A multiply or divide result is computed at issue, held in a
// pending register, and committed after a fixed number of Busy cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mdu_ctrl_if.slave (A, B, MduOp, Start in; Busy, HI, LO, Out out)
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        busy_r, busy_next_s;
  logic [31:0] hi_r, hi_next_s;
  logic [31:0] lo_r, lo_next_s;
  logic [31:0] pend_hi_r, pend_hi_next_s;
  logic [31:0] pend_lo_r, pend_lo_next_s;
  logic        pend_we_r, pend_we_next_s;
  logic [31:0] out_s;

  // 32x32 product, operands sign- or zero-extended to 64 bits; returns {hi, lo}.
  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    if (sgn) begin
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
    end else begin
      ax = {32'd0, a};
      bx = {32'd0, b};
    end
    return ax * bx;
  endfunction

  // Division in 33-bit signed arithmetic so 0x80000000 / -1 yields 2^31,
  // whose low 32 bits are the required 0x80000000. Returns {rem, quot}.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [32:0] ax;
    logic signed [32:0] bx;
    logic signed [32:0] q;
    logic signed [32:0] r;
    if (sgn) begin
      ax = {a[31], a};
      bx = {b[31], b};
    end else begin
      ax = {1'b0, a};
      bx = {1'b0, b};
    end
    if (bx == 33'sd0) begin
      q = 33'sd0;
      r = 33'sd0;
    end else begin
      q = ax / bx;
      r = ax % bx;
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Next-state logic: issue, countdown and commit.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    busy_next_s    = busy_r;
    hi_next_s      = hi_r;
    lo_next_s      = lo_r;
    pend_hi_next_s = pend_hi_r;
    pend_lo_next_s = pend_lo_r;
    pend_we_next_s = pend_we_r;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          case (bus.MduOp)
            OP_MULT, OP_MULTU: begin
              {pend_hi_next_s, pend_lo_next_s} = mul_fn(bus.A, bus.B, bus.MduOp == OP_MULT);
              pend_we_next_s = 1'b1;
              cnt_next_s     = MULT_N;
              busy_next_s    = 1'b1;
              state_next_s   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              {pend_hi_next_s, pend_lo_next_s} = div_fn(bus.A, bus.B, bus.MduOp == OP_DIV);
              // Divide by zero still runs the full period but commits nothing.
              pend_we_next_s = (bus.B != 32'd0);
              cnt_next_s     = DIV_N;
              busy_next_s    = 1'b1;
              state_next_s   = RUN;
            end
            OP_MTHI: hi_next_s = bus.A;
            OP_MTLO: lo_next_s = bus.A;
            default: ;
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        // Requests arriving while running are ignored.
        if (cnt_r == 4'd1) begin
          if (pend_we_r) begin
            hi_next_s = pend_hi_r;
            lo_next_s = pend_lo_r;
          end else begin
            hi_next_s = hi_r;
          end
          cnt_next_s   = 4'd0;
          busy_next_s  = 1'b0;
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State and architectural registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      busy_r    <= busy_next_s;
      hi_r      <= hi_next_s;
      lo_r      <= lo_next_s;
      pend_hi_r <= pend_hi_next_s;
      pend_lo_r <= pend_lo_next_s;
      pend_we_r <= pend_we_next_s;
    end
  end

  // MFHI/MFLO read mux; returns committed values even while running.
  always_comb begin
    case (bus.MduOp)
      OP_MFHI: out_s = hi_r;
      OP_MFLO: out_s = lo_r;
      default: out_s = 32'd0;
    endcase
  end

  assign bus.Busy = busy_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;
  assign bus.Out  = out_s;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random ops,
// checked against a longint arithmetic reference model.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  // Reference: new HI/LO for an op, whether it writes them, and its Busy length.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = ref_hi; nl = ref_lo; n = 0;
    case (op)
      4'd1: begin q = sa * sb; nh = q[63:32]; nl = q[31:0]; n = 5; end
      4'd2: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; n = 5; end
      4'd3: begin
        n = 10;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; end
      end
      4'd4: begin
        n = 10;
        if (b != 32'd0) begin up = ua / ub; nh = 32'(ua % ub); nl = up[31:0]; end
      end
      4'd7: nh = a;
      4'd8: nl = a;
      default: ;
    endcase
  endtask

  // Issue one op from IDLE, check Busy length, hold of HI/LO, result and read mux.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int n, cnt;
    model(op, a, b, nh, nl, n);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.MduOp = op; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MduOp = 4'd0; bus.A = $urandom; bus.B = $urandom;
    cnt = 0;
    while (bus.Busy === 1'b1 && cnt < 20) begin
      checks++;
      if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
        failures++;
        $display("FAIL %s_hold: HI=%h LO=%h expected HI=%h LO=%h", name, bus.HI, bus.LO, ref_hi, ref_lo);
      end
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== n) begin
      failures++;
      $display("FAIL %s_busy_len: got %0d cycles expected %0d", name, cnt, n);
    end
    ref_hi = nh; ref_lo = nl;
    checks++;
    if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
      failures++;
      $display("FAIL %s_result: HI=%h LO=%h expected HI=%h LO=%h", name, bus.HI, bus.LO, ref_hi, ref_lo);
    end
    bus.MduOp = 4'd5; #1;
    checks++;
    if (bus.Out !== ref_hi) begin
      failures++;
      $display("FAIL %s_mfhi: Out=%h expected %h", name, bus.Out, ref_hi);
    end
    bus.MduOp = 4'd6; #1;
    checks++;
    if (bus.Out !== ref_lo) begin
      failures++;
      $display("FAIL %s_mflo: Out=%h expected %h", name, bus.Out, ref_lo);
    end
    bus.MduOp = 4'd0; #1;
    checks++;
    if (bus.Out !== 32'd0) begin
      failures++;
      $display("FAIL %s_none_out: Out=%h expected 0", name, bus.Out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.Start = 1'b0; bus.MduOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.MduOp = 4'd5; #1;
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0 || bus.Out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: HI=%h LO=%h Busy=%b Out=%h expected all 0", bus.HI, bus.LO, bus.Busy, bus.Out);
    end
    bus.MduOp = 4'd0;
    ref_hi = 32'd0; ref_lo = 32'd0;
  endtask

  task automatic test_mult();
    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
  endtask

  task automatic test_div();
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2);
    run_op("divu", 4'd4, 32'd7, 32'd2);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_mthi_div0();
    run_op("mthi", 4'd7, 32'h12345678, 32'd0);
    run_op("div0", 4'd3, 32'd99, 32'd0);
    run_op("divu0", 4'd4, 32'd5, 32'd0);
  endtask

  task automatic test_ignore_in_run();
    logic [31:0] nh, nl;
    int n, cnt;
    model(4'd1, 32'd1000, 32'd7, nh, nl, n);
    @(negedge clk);
    bus.A = 32'd1000; bus.B = 32'd7; bus.MduOp = 4'd1; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MduOp = 4'd0;
    cnt = 1;
    @(negedge clk);
    bus.A = 32'hDEADBEEF; bus.MduOp = 4'd8; bus.Start = 1'b1;
    cnt++;
    @(negedge clk);
    bus.A = 32'd5; bus.B = 32'd5; bus.MduOp = 4'd1; bus.Start = 1'b1;
    cnt++;
    @(negedge clk);
    bus.Start = 1'b0; bus.MduOp = 4'd0;
    while (bus.Busy === 1'b1 && cnt < 20) begin
      checks++;
      if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
        failures++;
        $display("FAIL ignore_hold: HI=%h LO=%h expected HI=%h LO=%h", bus.HI, bus.LO, ref_hi, ref_lo);
      end
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== n) begin
      failures++;
      $display("FAIL ignore_busy_len: got %0d cycles expected %0d", cnt, n);
    end
    ref_hi = nh; ref_lo = nl;
    checks++;
    if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
      failures++;
      $display("FAIL ignore_result: HI=%h LO=%h expected HI=%h LO=%h", bus.HI, bus.LO, ref_hi, ref_lo);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== ref_hi || bus.LO !== ref_lo) begin
      failures++;
      $display("FAIL ignore_after: Busy=%b HI=%h LO=%h expected 0 %h %h", bus.Busy, bus.HI, bus.LO, ref_hi, ref_lo);
    end
  endtask

  task automatic test_reset_mid();
    run_op("pre_mthi", 4'd7, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    bus.A = 32'hFFFFFFFE; bus.B = 32'd3; bus.MduOp = 4'd1; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MduOp = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: Busy=%b HI=%h LO=%h expected 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_no_commit: Busy=%b HI=%h LO=%h expected 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_reset_with_start();
    @(negedge clk);
    reset = 1'b1; bus.A = 32'h7; bus.B = 32'h9; bus.MduOp = 4'd1; bus.Start = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.Start = 1'b0; bus.MduOp = 4'd0;
    checks++;
    if (bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_busy: Busy=%b expected 0", bus.Busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_result: Busy=%b HI=%h LO=%h expected 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
    run_op("mtlo_after_rst", 4'd8, 32'hDEADBEEF, 32'd0);
  endtask

  task automatic test_random();
    logic [3:0] ops [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd0, 4'd12};
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        a = 32'h80000000; b = 32'hFFFFFFFF;
      end
      run_op("rand", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_div0();
    test_ignore_in_run();
    test_reset_mid();
    test_reset_with_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
